// File: rtl/mem_resp_sram.sv
// Single-outstanding load/store responder backed by a word-organised SRAM.
// Fixed LATENCY cycles from accept to resp_valid; the response is held until resp_ready.
module mem_resp_sram #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN     = 33'(4 * DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        accept, do_access;

  logic        wen_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wmask_q;

  logic        acc_wen;
  logic [31:0] acc_addr, acc_wdata;
  logic [3:0]  acc_wmask;

  logic [31:0] off;
  logic [AW-1:0] idx;
  logic [1:0]  lane;
  logic [7:0]  m;
  logic [31:0] d;
  logic        oor, mis, err, mem_we;
  logic [31:0] word, rdata_nxt;

  logic [31:0] mem [DEPTH_WORDS];

  assign accept = req_valid && req_ready;

  // With LATENCY==1 the access happens on the accept edge, so IDLE uses the live request.
  always_comb begin
    if (state == IDLE) begin
      acc_wen   = req_wen;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_wmask = req_wmask;
    end else begin
      acc_wen   = wen_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_wmask = wmask_q;
    end
  end

  // Addresses below BASE_ADDR wrap to huge offsets and fall out of range naturally.
  assign off       = acc_addr - BASE_ADDR;
  assign idx       = off[AW+1:2];
  assign lane      = off[1:0];
  assign oor       = {1'b0, off} >= SPAN;
  assign m         = {4'b0000, acc_wmask} << lane;
  assign d         = acc_wdata << {lane, 3'b000};
  assign mis       = acc_wen && (m[7:4] != 4'b0000);
  assign err       = oor || mis;
  assign word      = mem[idx];
  assign rdata_nxt = (err || acc_wen) ? 32'h0 : (word >> {lane, 3'b000});
  assign mem_we    = do_access && acc_wen && !err;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    do_access = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            do_access = 1'b1;
            state_nxt = RESP;
          end else begin
            cnt_nxt   = CNT_INIT;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          do_access = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state, so ready only rises after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      wen_q      <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      wmask_q    <= 4'h0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      req_ready  <= (state_nxt == IDLE);
      resp_valid <= (state_nxt == RESP);
      if (accept) begin
        wen_q   <= req_wen;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wmask_q <= req_wmask;
      end
      if (do_access) begin
        resp_rdata <= rdata_nxt;
        resp_err   <= err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (m[k]) mem[idx][8*k +: 8] <= d[8*k +: 8];
      end
    end
  end

endmodule
